// File: rtl/msdap_serial_tx_pkg.sv
// Shared definitions for the MSDAP serial transmitter: default sizes,
// FSM state encoding and a helper for counter widths.
package msdap_serial_tx_pkg;

   localparam int WORD_W_DEFAULT     = 16;
   localparam int FIFO_DEPTH_DEFAULT = 4;
   localparam int GAP_CYCLES_DEFAULT = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } tx_state_e;

   // Width needed to hold values 0..max_value, never less than one bit.
   function automatic int cnt_width(input int max_value);
      return (max_value < 2) ? 1 : $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/msdap_sync_fifo.sv
// Single-clock FIFO holding one stereo word per entry. Head entry is visible
// on pop_data without a read latency so the transmitter can load it on the
// same edge it pops. Pushes into a full FIFO and pops from an empty one are
// ignored.
module msdap_sync_fifo
   import msdap_serial_tx_pkg::*;
#(
   parameter int WIDTH = 2 * WORD_W_DEFAULT,
   parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == DEPTH_CNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two; a simultaneous
   // push and pop leaves the occupancy unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/msdap_serial_tx.sv
// Host-side transmitter for the MSDAP serial input port. Buffers parallel
// stereo words and shifts them out MSB-first on InputL/InputR with a Frame
// marker on the MSB cycle. A new word only starts when the chip reports
// InReady; once started, a word always runs to completion.
module msdap_serial_tx
   import msdap_serial_tx_pkg::*;
#(
   parameter int WORD_W     = WORD_W_DEFAULT,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
   parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
   input  logic              Dclk,
   input  logic              Reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_dataL,
   input  logic [WORD_W-1:0] in_dataR,
   input  logic              InReady,
   output logic              Frame,
   output logic              InputL,
   output logic              InputR,
   output logic              busy,
   output logic              word_sent
);

   localparam int BIT_W = $clog2(WORD_W);
   localparam int GAP_W = cnt_width(GAP_CYCLES);
   localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(WORD_W - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

   tx_state_e         state;
   tx_state_e         state_next;
   logic [BIT_W-1:0]  bit_cnt;
   logic [BIT_W-1:0]  bit_cnt_next;
   logic [GAP_W-1:0]  gap_cnt;
   logic [GAP_W-1:0]  gap_cnt_next;
   logic [WORD_W-1:0] sr_l;
   logic [WORD_W-1:0] sr_l_next;
   logic [WORD_W-1:0] sr_r;
   logic [WORD_W-1:0] sr_r_next;
   logic              frame_q;
   logic              frame_next;
   logic              input_l_q;
   logic              input_l_next;
   logic              input_r_q;
   logic              input_r_next;
   logic              word_sent_q;
   logic              word_sent_next;

   logic                fifo_push;
   logic                fifo_full;
   logic                fifo_empty;
   logic [2*WORD_W-1:0] head_data;
   logic [WORD_W-1:0]   head_l;
   logic [WORD_W-1:0]   head_r;

   logic start_ok;
   logic last_bit;
   logic gap_done;
   logic launch;

   assign in_ready  = !fifo_full;
   assign fifo_push = in_valid && in_ready;
   assign head_l    = head_data[2*WORD_W-1:WORD_W];
   assign head_r    = head_data[WORD_W-1:0];

   // A word may begin whenever data is queued and the chip is ready; this
   // is evaluated from IDLE, straight after bit 0, or at the end of a gap.
   assign start_ok = !fifo_empty && InReady;
   assign last_bit = (state == ST_SHIFT) && (bit_cnt == '0);
   assign gap_done = (state == ST_GAP) && (gap_cnt == GAP_ONE);
   assign launch   = start_ok &&
                     ((state == ST_IDLE) || (last_bit && (GAP_CYCLES == 0)) || gap_done);

   assign busy      = (state != ST_IDLE) || !fifo_empty;
   assign Frame     = frame_q;
   assign InputL    = input_l_q;
   assign InputR    = input_r_q;
   assign word_sent = word_sent_q;

   msdap_sync_fifo #(
      .WIDTH (2 * WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (Dclk),
      .rst_n     (Reset_n),
      .push      (fifo_push),
      .push_data ({in_dataL, in_dataR}),
      .pop       (launch),
      .pop_data  (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // State, counters, shift registers and the registered serial outputs;
   // reset drops every output at once and abandons any partial word.
   always_ff @(posedge Dclk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         gap_cnt     <= '0;
         sr_l        <= '0;
         sr_r        <= '0;
         frame_q     <= 1'b0;
         input_l_q   <= 1'b0;
         input_r_q   <= 1'b0;
         word_sent_q <= 1'b0;
      end else begin
         state       <= state_next;
         bit_cnt     <= bit_cnt_next;
         gap_cnt     <= gap_cnt_next;
         sr_l        <= sr_l_next;
         sr_r        <= sr_r_next;
         frame_q     <= frame_next;
         input_l_q   <= input_l_next;
         input_r_q   <= input_r_next;
         word_sent_q <= word_sent_next;
      end
   end

   // Next-state selection: shift for a whole word, then optionally idle out
   // the gap, then either start the next word or fall back to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start_ok) begin
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (bit_cnt == '0) begin
               if (GAP_CYCLES > 0) begin
                  state_next = ST_GAP;
               end else if (start_ok) begin
                  state_next = ST_SHIFT;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt == GAP_ONE) begin
               state_next = start_ok ? ST_SHIFT : ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Datapath and output values for the next cycle: a launch loads the FIFO
   // head and drives its MSB with Frame, shifting walks down to bit 0, and
   // everything outside a word drives zero.
   always_comb begin
      bit_cnt_next   = bit_cnt;
      gap_cnt_next   = gap_cnt;
      sr_l_next      = sr_l;
      sr_r_next      = sr_r;
      frame_next     = 1'b0;
      input_l_next   = 1'b0;
      input_r_next   = 1'b0;
      word_sent_next = 1'b0;
      if (launch) begin
         sr_l_next    = head_l;
         sr_r_next    = head_r;
         bit_cnt_next = BIT_MSB;
         frame_next   = 1'b1;
         input_l_next = head_l[WORD_W-1];
         input_r_next = head_r[WORD_W-1];
      end else begin
         case (state)
            ST_SHIFT: begin
               if (bit_cnt != '0) begin
                  sr_l_next      = sr_l << 1;
                  sr_r_next      = sr_r << 1;
                  input_l_next   = sr_l[WORD_W-2];
                  input_r_next   = sr_r[WORD_W-2];
                  bit_cnt_next   = bit_cnt - BIT_ONE;
                  word_sent_next = (bit_cnt == BIT_ONE);
               end else if (GAP_CYCLES > 0) begin
                  gap_cnt_next = GAP_LOAD;
               end
            end
            ST_GAP: begin
               if (gap_cnt != GAP_ONE) begin
                  gap_cnt_next = gap_cnt - GAP_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
